// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use bubbles,
// taken-branch flushes, multi-cycle multiply stalls and a saturating stall counter.
module hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_mul,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             idex_hold,
    output logic             mul_busy,
    output logic [15:0]      stall_cycles
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic {RUN, MUL_BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lu;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A load in EX feeding a register read in ID; r0 never carries a dependency.
    always_comb begin
        lu = ex_mem_read && (ex_dest != '0) &&
             ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)));
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        idex_hold  = 1'b0;
        mul_busy   = 1'b0;
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state == MUL_BUSY) begin
            // EX is occupied by the multiply, so branch and load-use are moot here.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_hold = 1'b1;
            mul_busy  = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= 16'd0;
        end else begin
            if (!pc_en) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            case (state)
                RUN: begin
                    if (!branch_taken && !lu && id_is_mul && (MUL_LAT > 1)) begin
                        state <= MUL_BUSY;
                        cnt   <= CNT_W'(MUL_LAT - 1);
                    end
                end
                MUL_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, randomized run against a reference
// model, and stall-counter saturation, on MUL_LAT=4 and MUL_LAT=1 instances.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_dest;
    logic       id_uses_rs, id_uses_rt, id_is_mul, ex_mem_read, branch_taken;

    logic        pc_en4, ifid_en4, ifid_flush4, idex_flush4, idex_hold4, mul_busy4;
    logic [15:0] stall4_o;
    logic        pc_en1, ifid_en1, ifid_flush1, idex_flush1, idex_hold1, mul_busy1;
    logic [15:0] stall1_o;

    hazard_ctrl #(.REG_W(5), .MUL_LAT(4)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_mul(id_is_mul),
        .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4),
        .idex_flush(idex_flush4), .idex_hold(idex_hold4), .mul_busy(mul_busy4),
        .stall_cycles(stall4_o)
    );

    hazard_ctrl #(.REG_W(5), .MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_mul(id_is_mul),
        .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
        .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
        .idex_flush(idex_flush1), .idex_hold(idex_hold1), .mul_busy(mul_busy1),
        .stall_cycles(stall1_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control outputs packed as {pc_en, ifid_en, ifid_flush, idex_flush, idex_hold, mul_busy}
    localparam logic [5:0] NRM = 6'b110000;
    localparam logic [5:0] LUS = 6'b000100;
    localparam logic [5:0] BSY = 6'b000011;
    localparam logic [5:0] RST = 6'b001100;
    localparam logic [5:0] BRF = 6'b111100;

    typedef struct {
        logic        rst, br, mr;
        logic [4:0]  exd;
        logic        urs;
        logic [4:0]  rs;
        logic        urt;
        logic [4:0]  rt;
        logic        mul;
        logic [5:0]  ctl;
        logic [15:0] st;
    } vec_t;

    vec_t tbl[25];

    int vectors    = 0;
    int miscompares = 0;
    int busy4 = 0, busy1 = 0, stall4 = 0, stall1 = 0;

    function automatic bit lu_f();
        return ex_mem_read && (ex_dest != 0) &&
               ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
    endfunction

    function automatic logic [5:0] exp_ctl(int busy_left);
        if (rst)               return RST;
        if (busy_left > 0)     return BSY;
        if (branch_taken)      return BRF;
        if (lu_f())            return LUS;
        return NRM;
    endfunction

    task automatic model_step(input int lat, inout int busy_left, inout int stalls);
        logic [5:0] e;
        e = exp_ctl(busy_left);
        if (rst) begin
            busy_left = 0;
            stalls    = 0;
        end else begin
            if (!e[5]) stalls = (stalls >= 65535) ? 65535 : stalls + 1;
            if (busy_left > 0) busy_left = busy_left - 1;
            else if (!branch_taken && !lu_f() && id_is_mul && lat > 1) busy_left = lat - 1;
        end
    endtask

    task automatic check(input string name, input int idx, input logic [21:0] act,
                         input logic [21:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s[%0d]: actual ctl=%b stall=%h required ctl=%b stall=%h",
                     name, idx, act[21:16], act[15:0], req[21:16], req[15:0]);
        end
    endtask

    task automatic run_cycle(input bit chk, input int row);
        @(negedge clk);
        if (chk) begin
            check("model_lat4", vectors,
                  {pc_en4, ifid_en4, ifid_flush4, idex_flush4, idex_hold4, mul_busy4, stall4_o},
                  {exp_ctl(busy4), 16'(stall4)});
            check("model_lat1", vectors,
                  {pc_en1, ifid_en1, ifid_flush1, idex_flush1, idex_hold1, mul_busy1, stall1_o},
                  {exp_ctl(busy1), 16'(stall1)});
        end
        if (row >= 0) begin
            check("table", row,
                  {pc_en4, ifid_en4, ifid_flush4, idex_flush4, idex_hold4, mul_busy4, stall4_o},
                  {tbl[row].ctl, tbl[row].st});
        end
        model_step(4, busy4, stall4);
        model_step(1, busy1, stall1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, br, mr, input logic [4:0] exd, input logic urs,
                         input logic [4:0] rs, input logic urt, input logic [4:0] rt,
                         input logic mul);
        rst = r; branch_taken = br; ex_mem_read = mr; ex_dest = exd;
        id_uses_rs = urs; id_rs = rs; id_uses_rt = urt; id_rt = rt; id_is_mul = mul;
    endtask

    initial begin
        //          rst br mr exd   urs rs    urt rt    mul ctl  stall
        tbl[0]  = '{1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, RST, 16'd0};
        tbl[1]  = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, NRM, 16'd0};
        tbl[2]  = '{0, 0, 1, 5'd8, 1, 5'd8, 0, 5'd0, 0, LUS, 16'd0};
        tbl[3]  = '{0, 0, 0, 5'd8, 1, 5'd8, 0, 5'd0, 0, NRM, 16'd1};
        tbl[4]  = '{0, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, NRM, 16'd1};
        tbl[5]  = '{0, 0, 1, 5'd8, 0, 5'd8, 1, 5'd9, 0, NRM, 16'd1};
        tbl[6]  = '{0, 0, 1, 5'd9, 0, 5'd0, 1, 5'd9, 0, LUS, 16'd1};
        tbl[7]  = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, NRM, 16'd2};
        tbl[8]  = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, NRM, 16'd2};
        tbl[9]  = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, BSY, 16'd2};
        tbl[10] = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, BSY, 16'd3};
        tbl[11] = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, BSY, 16'd4};
        tbl[12] = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, NRM, 16'd5};
        tbl[13] = '{0, 1, 1, 5'd8, 1, 5'd8, 0, 5'd0, 0, BRF, 16'd5};
        tbl[14] = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, NRM, 16'd5};
        tbl[15] = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, NRM, 16'd5};
        tbl[16] = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, BSY, 16'd5};
        tbl[17] = '{0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, BSY, 16'd6};
        tbl[18] = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, BSY, 16'd7};
        tbl[19] = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, NRM, 16'd8};
        tbl[20] = '{0, 0, 1, 5'd8, 1, 5'd8, 0, 5'd0, 1, LUS, 16'd8};
        tbl[21] = '{0, 0, 0, 5'd8, 1, 5'd8, 0, 5'd0, 1, NRM, 16'd9};
        tbl[22] = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, BSY, 16'd9};
        tbl[23] = '{1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, RST, 16'd10};
        tbl[24] = '{0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, NRM, 16'd0};

        // First reset cycle: state is still unknown, so it is not compared.
        drive(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
        @(posedge clk);
        #1;
        run_cycle(0, -1);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].rst, tbl[i].br, tbl[i].mr, tbl[i].exd, tbl[i].urs, tbl[i].rs,
                  tbl[i].urt, tbl[i].rt, tbl[i].mul);
            run_cycle(1, i);
        end

        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(63) == 0, $urandom_range(7) == 0, 1'($urandom_range(1)),
                  5'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(3)),
                  1'($urandom_range(1)), 5'($urandom_range(3)), $urandom_range(4) == 0);
            run_cycle(1, -1);
        end

        // Hold a load-use hazard long enough to drive the counter past its ceiling.
        drive(1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
        run_cycle(1, -1);
        drive(0, 0, 1, 5'd8, 1, 5'd8, 0, 5'd0, 0);
        for (int i = 0; i < 65540; i++) run_cycle(0, -1);
        run_cycle(1, -1);
        @(negedge clk);
        check("saturate", 0, {pc_en4, stall4_o}, {1'b0, 16'hFFFF});
        @(posedge clk);
        #1;
        drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
        @(negedge clk);
        check("saturate_hold", 0, {pc_en4, ifid_en4, stall4_o}, {2'b11, 16'hFFFF});
        check("saturate_hold_lat1", 0, {pc_en1, ifid_en1, stall1_o}, {2'b11, 16'hFFFF});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS pipelined CPU. It watches the instruction in ID and the instruction in EX and drives the enable, flush and hold controls of the PC, IF/ID and ID/EX pipeline registers. It resolves three cases: load-use hazards with a one-cycle bubble, taken branches with a flush of the two younger stages, and multi-cycle multiply occupancy of EX with a counter-driven stall. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface

Parameters:
- REG_W, 5: register-address width.
- MUL_LAT, 4: total number of cycles a multiply occupies EX. Must be at least 1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset. Synchronous, active-high.
- id_rs, input, REG_W: rs address of the instruction in ID.
- id_rt, input, REG_W: rt address of the instruction in ID.
- id_uses_rs, input, 1: the ID instruction reads rs.
- id_uses_rt, input, 1: the ID instruction reads rt.
- id_is_mul, input, 1: the ID instruction is a multi-cycle multiply.
- ex_dest, input, REG_W: destination address of the instruction in EX.
- ex_mem_read, input, 1: the EX instruction is a load.
- branch_taken, input, 1: a branch was resolved taken in EX this cycle.
- pc_en, output, 1: PC update enable.
- ifid_en, output, 1: IF/ID load enable.
- ifid_flush, output, 1: clear IF/ID to a NOP on the next edge.
- idex_flush, output, 1: load a bubble (all zeros) into ID/EX on the next edge.
- idex_hold, output, 1: ID/EX keeps its current contents.
- mul_busy, output, 1: the FSM is in MUL_BUSY.
- stall_cycles, output, 16: saturating count of stalled cycles.

## Operation

Outputs are a combinational function of the FSM state and the current inputs. Only the state, cnt and stall_cycles are registered.

FSM states:
- RUN (reset state).
- MUL_BUSY.

Internal signals:
- cnt: width $clog2(MUL_LAT+1), reset value 0.
- lu: load-use hazard, true when all of the following hold:
  - ex_mem_read = 1;
  - ex_dest ≠ 0;
  - (id_uses_rs and id_rs = ex_dest) or (id_uses_rt and id_rt = ex_dest).

RUN behaviour, in priority order:
1. branch_taken:
   - pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, idex_hold=0.
   - lu and id_is_mul are ignored.
2. lu:
   - pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0, idex_hold=0.
3. id_is_mul, with MUL_LAT > 1:
   - Normal advance outputs: pc_en=1, ifid_en=1, all flush/hold signals 0.
   - Next state MUL_BUSY; cnt loaded with MUL_LAT-1.
4. Otherwise:
   - Normal advance; state stays RUN.
   - With MUL_LAT = 1, a multiply never enters MUL_BUSY.

MUL_BUSY behaviour:
- Outputs: pc_en=0, ifid_en=0, idex_hold=1, idex_flush=0, ifid_flush=0, mul_busy=1.
- branch_taken and lu are ignored, because EX holds the multiply.
- cnt decrements by 1 each cycle.
- When cnt = 1, the next state is RUN and cnt goes to 0.

stall_cycles:
- Increments by 1 on each edge where rst=0 and pc_en=0.
- Saturates at 16'hFFFF; it does not wrap.

Reset behaviour:
- While rst=1: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, idex_hold=0, mul_busy=0.
- At the edge: state←RUN, cnt←0, stall_cycles←0.
- Reset during MUL_BUSY abandons the multiply immediately.

## Timing

- Load-use: the stall lasts exactly one cycle. On the following cycle EX holds the bubble (ex_mem_read=0), so lu clears without any extra state.
- Multiply:
  - The multiply is in ID in cycle t and enters EX at the edge ending t.
  - mul_busy=1 for cycles t+1 through t+MUL_LAT-1, i.e. MUL_LAT-1 stall cycles.
  - In cycle t+MUL_LAT the pipeline advances and the multiply leaves EX.
- Branch: the flush takes effect on the edge ending the cycle in which branch_taken=1. The flush costs 2 bubbles and adds nothing to stall_cycles.
- A load-use hazard behind a multiply in ID: stall first, then the multiply issues the next cycle.
- The first cycle after reset deasserts is RUN with normal advance, assuming no hazard.

## Test plan

- **Reset:** hold rst 2 cycles, then release.
  - During reset: pc_en=0, ifid_flush=1, idex_flush=1.
  - After release: pc_en=1, ifid_en=1, flush/hold all 0, stall_cycles=0.
- **Load-use:** ex_mem_read=1, ex_dest=8, id_uses_rs=1, id_rs=8.
  - One cycle with pc_en=0, ifid_en=0, idex_flush=1, then normal advance; stall_cycles=1.
  - Repeat with ex_dest=0: no stall.
  - Repeat with id_uses_rs=0: no stall.
- **Multiply, MUL_LAT=4:** id_is_mul=1 for one cycle.
  - mul_busy=1, idex_hold=1, pc_en=0 for exactly 3 cycles, then RUN; stall_cycles=3.
  - Repeat with MUL_LAT=1: no mul_busy at all.
- **Branch priority:** branch_taken=1 in the same cycle as an lu condition.
  - ifid_flush=1, idex_flush=1, pc_en=1; no stall; stall_cycles unchanged.
- **Branch during MUL_BUSY:** assert branch_taken in cycle 2 of MUL_BUSY.
  - Ignored; the busy period still ends after 3 cycles.
- **Mid-operation reset and saturation:**
  - Assert rst in cycle 2 of MUL_BUSY: next cycle state is RUN, mul_busy=0.
  - Force more than 65535 stall cycles: stall_cycles holds at 16'hFFFF.
